// File: rtl/rr_mux8_arbiter.sv
// rtl/rr_mux8_arbiter.sv - round-robin arbiter owning the select of an 8:1 single-bit mux
module rr_mux8_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [7:0] grant_n;
    logic [2:0] sel_n;
    logic       busy_n;
    logic [3:0] hold_cnt, hold_n;
    logic [2:0] last, last_n;

    logic [7:0] cand;
    logic       other_pending;
    logic       hold_expired;
    logic       release_now;

    // First set bit of mask, scanning upward from start with 3-bit wrap.
    function automatic logic [2:0] rr_pick(input logic [2:0] start, input logic [7:0] mask);
        logic [2:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign cand          = req & ~grant;
    assign other_pending = |cand;
    assign hold_expired  = (hold_cnt == 4'(MAX_HOLD));
    assign release_now   = !req[sel] || (hold_expired && other_pending);

    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = sel;
        busy_n  = busy;
        hold_n  = hold_cnt;
        last_n  = last;
        case (state)
            IDLE: begin
                if (req != 8'h00) begin
                    sel_n   = rr_pick(last + 3'd1, req);
                    grant_n = 8'(1) << sel_n;
                    busy_n  = 1'b1;
                    hold_n  = 4'd1;
                    last_n  = sel_n;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    if (!hold_expired) begin
                        hold_n = hold_cnt + 4'd1;
                    end
                end else if (other_pending) begin
                    // Handover: the released requester is already masked out of cand.
                    sel_n   = rr_pick(sel + 3'd1, cand);
                    grant_n = 8'(1) << sel_n;
                    hold_n  = 4'd1;
                    last_n  = sel_n;
                end else begin
                    grant_n = 8'h00;
                    busy_n  = 1'b0;
                    hold_n  = 4'd0;
                    last_n  = sel;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 8'h00;
            sel      <= 3'd0;
            busy     <= 1'b0;
            hold_cnt <= 4'd0;
            last     <= 3'd7;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            sel      <= sel_n;
            busy     <= busy_n;
            hold_cnt <= hold_n;
            last     <= last_n;
        end
    end

    assign out = busy ? data_in[sel] : 1'b0;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// tb/tb_rr_mux8_arbiter.sv - directed self-checking bench for rr_mux8_arbiter
module tb_rr_mux8_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] data_in;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       out;

    int n_checks = 0;
    int n_pass   = 0;

    rr_mux8_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_in (data_in),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    logic [7:0] pat;
    logic [2:0] idx;

    initial begin
        rst_n   = 1'b0;
        req     = 8'h00;
        data_in = 8'h00;
        step(2);
        check("reset_outputs", {grant, sel, busy, out}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("idle_outputs", {grant, sel, busy, out}, 32'h0);
        end

        // Single requester 5 keeps the grant past MAX_HOLD when nobody else waits
        req     = 8'h20;
        data_in = 8'h20;
        step(1);
        check("single_grant", grant, 8'h20);
        check("single_sel", sel, 3'd5);
        check("single_busy", busy, 1'b1);
        check("single_out_hi", out, 1'b1);
        data_in = 8'hDF;
        #1;
        check("single_out_lo", out, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("single_hold", grant, 8'h20);
        end
        req = 8'h00;
        step(1);
        check("single_drop_grant", grant, 8'h00);
        check("single_drop_busy", busy, 1'b0);
        check("single_drop_sel", sel, 3'd5);
        check("single_drop_out", out, 1'b0);

        // Round robin with everyone requesting: 4 cycles each, no idle gap
        do_reset();
        pat     = 8'hA5;
        data_in = pat;
        req     = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            idx = 3'(g);
            for (int c = 0; c < 4; c++) begin
                step(1);
                check("rr_grant", grant, 8'h01 << idx);
                check("rr_sel", sel, idx);
                check("rr_out", out, pat[idx]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_grant", grant, 8'h00);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_out", out, 1'b0);
        step(1);
        rst_n = 1'b1;
        req   = 8'h00;
        step(1);

        // Early release of 7 wraps to 0; 7 re-requests and waits for 0's tenure
        req = 8'h80;
        step(1);
        check("wrap_g7", grant, 8'h80);
        req = 8'h81;
        step(1);
        check("wrap_g7_hold", grant, 8'h80);
        req = 8'h01;
        step(1);
        check("wrap_g0", grant, 8'h01);
        check("wrap_sel0", sel, 3'd0);
        req = 8'h81;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("wrap_g0_hold", grant, 8'h01);
        end
        step(1);
        check("wrap_back_g7", grant, 8'h80);

        // Drop of req[2] coinciding with hold expiry: one handover to 3
        do_reset();
        req = 8'h0C;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("sim_g2", grant, 8'h04);
        end
        req = 8'h18;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("sim_g3", grant, 8'h08);
        end
        step(1);
        check("sim_g4", grant, 8'h10);

        // Idle return, then search restarts after last=6
        do_reset();
        req = 8'h40;
        step(1);
        check("idle_ret_g6", grant, 8'h40);
        req = 8'h00;
        step(1);
        check("idle_ret_grant", grant, 8'h00);
        check("idle_ret_busy", busy, 1'b0);
        req = 8'h41;
        step(1);
        check("idle_ret_g0", grant, 8'h01);
        check("idle_ret_sel0", sel, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
